kong_keypad_ctrl: RTL and testbench

- Input-conditioning stage directly upstream of the Kong movement logic.
- Debounces the raw keypad decoder output {keyIsPressed, keyCode} and maps keys to movement requests (ask_move_up/down/left/right/jump).
- Movement requests are frame-stable: updated only on startOfFrame.
- Jump is edge-triggered (one frame per press). A key-sequence detector toggles a cheat-mode flag.

---
 rtl/kong_keypad_ctrl.sv | 148 ++++++++++++++
 tb/tb_kong_keypad_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kong_keypad_ctrl.sv
// Keypad input conditioning for Kong: synchronise and debounce the raw keypad,
// latch movement requests once per frame, edge-detect jump, and toggle cheat mode.
module kong_keypad_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES      = 16,
    parameter int unsigned CHEAT_TIMEOUT_FRAMES = 120,
    parameter logic [3:0]  KEY_UP               = 4'd2,
    parameter logic [3:0]  KEY_DOWN             = 4'd8,
    parameter logic [3:0]  KEY_LEFT             = 4'd4,
    parameter logic [3:0]  KEY_RIGHT            = 4'd6,
    parameter logic [3:0]  KEY_JUMP             = 4'd5,
    parameter logic [15:0] CHEAT_SEQ            = {4'd1, 4'd3, 4'd7, 4'd9}
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       keyIsPressed,
    input  logic [3:0] keyCode,
    output logic       ask_move_up,
    output logic       ask_move_down,
    output logic       ask_move_left,
    output logic       ask_move_right,
    output logic       ask_move_jump,
    output logic       cheat_mode
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned      FRM_W   = $clog2(CHEAT_TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(CHEAT_TIMEOUT_FRAMES);

    typedef enum logic [1:0] {IDLE, S1, S2, S3} cheat_state_t;

    logic [4:0]       sync1, sync2, raw_s;
    logic [4:0]       candidate, stable, stable_d;
    logic [CNT_W-1:0] db_cnt;
    logic             press_evt;
    logic [3:0]       stable_code;
    logic             dir_up, dir_down, dir_left, dir_right;
    logic             jump_evt, jump_pending;

    cheat_state_t     state, eff_state, next_state;
    logic [FRM_W-1:0] frame_cnt;
    logic             timeout, toggle;
    logic [3:0]       expected;

    // Released keys carry code 0 so a release always differs from any press.
    assign raw_s       = {sync2[4], sync2[4] ? sync2[3:0] : 4'd0};
    assign stable_code = stable[3:0];
    assign press_evt   = stable[4] && (!stable_d[4] || stable_d[3:0] != stable_code);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            stable    <= '0;
            stable_d  <= '0;
            db_cnt    <= '0;
        end else begin
            sync1    <= {keyIsPressed, keyCode};
            sync2    <= sync1;
            stable_d <= stable;
            if (raw_s != candidate) begin
                candidate <= raw_s;
                db_cnt    <= '0;
            end else if (db_cnt == CNT_MAX) begin
                stable <= candidate;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dir_up    = stable[4] && stable_code == KEY_UP;
        dir_down  = stable[4] && stable_code == KEY_DOWN;
        dir_left  = stable[4] && stable_code == KEY_LEFT;
        dir_right = stable[4] && stable_code == KEY_RIGHT;
        jump_evt  = press_evt && stable_code == KEY_JUMP;
    end

    // A jump event landing on the frame pulse is carried into the next frame.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            ask_move_up    <= 1'b0;
            ask_move_down  <= 1'b0;
            ask_move_left  <= 1'b0;
            ask_move_right <= 1'b0;
            ask_move_jump  <= 1'b0;
            jump_pending   <= 1'b0;
        end else if (startOfFrame) begin
            ask_move_up    <= dir_up;
            ask_move_down  <= dir_down;
            ask_move_left  <= dir_left;
            ask_move_right <= dir_right;
            ask_move_jump  <= jump_pending;
            jump_pending   <= jump_evt;
        end else if (jump_evt) begin
            jump_pending <= 1'b1;
        end
    end

    always_comb begin
        timeout    = (frame_cnt == FRM_MAX);
        eff_state  = timeout ? IDLE : state;
        next_state = eff_state;
        toggle     = 1'b0;
        case (eff_state)
            IDLE:    expected = CHEAT_SEQ[15:12];
            S1:      expected = CHEAT_SEQ[11:8];
            S2:      expected = CHEAT_SEQ[7:4];
            default: expected = CHEAT_SEQ[3:0];
        endcase
        if (press_evt) begin
            if (stable_code == expected) begin
                case (eff_state)
                    IDLE:    next_state = S1;
                    S1:      next_state = S2;
                    S2:      next_state = S3;
                    default: begin
                        next_state = IDLE;
                        toggle     = 1'b1;
                    end
                endcase
            end else if (stable_code == CHEAT_SEQ[15:12]) begin
                next_state = S1;
            end else begin
                next_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            cheat_mode <= 1'b0;
        end else begin
            state      <= next_state;
            cheat_mode <= cheat_mode ^ toggle;
            if (press_evt || next_state == IDLE)
                frame_cnt <= '0;
            else if (startOfFrame && state != IDLE && frame_cnt != FRM_MAX)
                frame_cnt <= frame_cnt + FRM_W'(1);
        end
    end

endmodule

// File: tb/tb_kong_keypad_ctrl.sv
// Directed bench for kong_keypad_ctrl: frame-latched moves, debounce, jump edge,
// and cheat sequence including restart, abort, timeout and reset.
module tb_kong_keypad_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       keyIsPressed = 1'b0;
    logic [3:0] keyCode = 4'd0;
    logic       ask_move_up, ask_move_down, ask_move_left, ask_move_right, ask_move_jump;
    logic       cheat_mode;
    logic [4:0] mv;

    int passed = 0;
    int total  = 0;

    kong_keypad_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .keyIsPressed   (keyIsPressed),
        .keyCode        (keyCode),
        .ask_move_up    (ask_move_up),
        .ask_move_down  (ask_move_down),
        .ask_move_left  (ask_move_left),
        .ask_move_right (ask_move_right),
        .ask_move_jump  (ask_move_jump),
        .cheat_mode     (cheat_mode)
    );

    always #5 clk = ~clk;

    // {up, down, left, right, jump}
    assign mv = {ask_move_up, ask_move_down, ask_move_left, ask_move_right, ask_move_jump};

    // Frame pulse sampled at the n-th rising edge from now; returns 1 unit after it.
    task automatic frame_after(input int n);
        repeat (n - 1) @(posedge clk);
        #1 startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] c);
        keyIsPressed = 1'b1;
        keyCode      = c;
        frame_after(40);
        frame_after(40);
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
    endtask

    task automatic test_reset;
        resetN       = 1'b1;
        startOfFrame = 1'b1;
        keyIsPressed = 1'b1;
        keyCode      = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mv !== 5'b00000) $display("FAIL reset_moves got=%b exp=%b", mv, 5'b00000);
        else passed++;
        total++;
        if (cheat_mode !== 1'b0) $display("FAIL reset_cheat got=%b exp=0", cheat_mode);
        else passed++;
        startOfFrame = 1'b0;
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        @(posedge clk);
        #1 resetN = 1'b0;
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_right_hold;
        keyIsPressed = 1'b1;
        keyCode      = 4'd6;
        frame_after(10);
        total++;
        if (mv !== 5'b00000) $display("FAIL right_early got=%b exp=%b", mv, 5'b00000);
        else passed++;
        frame_after(30);
        total++;
        if (mv !== 5'b00010) $display("FAIL right_first got=%b exp=%b", mv, 5'b00010);
        else passed++;
        frame_after(40);
        total++;
        if (mv !== 5'b00010) $display("FAIL right_held got=%b exp=%b", mv, 5'b00010);
        else passed++;
        repeat (20) @(posedge clk);
        #1 keyIsPressed = 1'b0;
        keyCode = 4'd0;
        repeat (25) @(posedge clk);
        #1;
        total++;
        if (mv !== 5'b00010) $display("FAIL right_framestable got=%b exp=%b", mv, 5'b00010);
        else passed++;
        frame_after(15);
        total++;
        if (mv !== 5'b00000) $display("FAIL right_release got=%b exp=%b", mv, 5'b00000);
        else passed++;
    endtask

    task automatic test_bounce;
        keyCode = 4'd6;
        for (int i = 0; i < 12; i++) begin
            keyIsPressed = (i % 2 == 0);
            repeat (4) @(posedge clk);
            #1 startOfFrame = (i % 4 == 3);
            @(posedge clk);
            #1 startOfFrame = 1'b0;
            if (i % 4 == 3) begin
                total++;
                if (mv !== 5'b00000) $display("FAIL bounce_quiet i=%0d got=%b exp=%b", i, mv, 5'b00000);
                else passed++;
            end
        end
        keyIsPressed = 1'b1;
        frame_after(40);
        total++;
        if (mv !== 5'b00010) $display("FAIL bounce_steady got=%b exp=%b", mv, 5'b00010);
        else passed++;
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
    endtask

    task automatic test_jump;
        keyIsPressed = 1'b1;
        keyCode      = 4'd5;
        frame_after(40);
        total++;
        if (mv !== 5'b00001) $display("FAIL jump_first got=%b exp=%b", mv, 5'b00001);
        else passed++;
        for (int f = 0; f < 4; f++) begin
            frame_after(40);
            total++;
            if (mv !== 5'b00000) $display("FAIL jump_norepeat f=%0d got=%b exp=%b", f, mv, 5'b00000);
            else passed++;
        end
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
        keyIsPressed = 1'b1;
        keyCode      = 4'd5;
        frame_after(40);
        total++;
        if (mv !== 5'b00001) $display("FAIL jump_second got=%b exp=%b", mv, 5'b00001);
        else passed++;
        frame_after(40);
        total++;
        if (mv !== 5'b00000) $display("FAIL jump_second_end got=%b exp=%b", mv, 5'b00000);
        else passed++;
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
    endtask

    // Key driven after edge E0: the press event is sampled at edge E20.
    task automatic test_jump_coincident;
        keyIsPressed = 1'b1;
        keyCode      = 4'd5;
        frame_after(20);
        total++;
        if (ask_move_jump !== 1'b0) $display("FAIL jump_coinc_now got=%b exp=0", ask_move_jump);
        else passed++;
        frame_after(40);
        total++;
        if (ask_move_jump !== 1'b1) $display("FAIL jump_coinc_next got=%b exp=1", ask_move_jump);
        else passed++;
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
        total++;
        if (ask_move_jump !== 1'b0) $display("FAIL jump_coinc_end got=%b exp=0", ask_move_jump);
        else passed++;
    endtask

    task automatic test_cheat;
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd7);
        total++;
        if (cheat_mode !== 1'b0) $display("FAIL cheat_partial got=%b exp=0", cheat_mode);
        else passed++;
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b1) $display("FAIL cheat_on got=%b exp=1", cheat_mode);
        else passed++;
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd7);
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b0) $display("FAIL cheat_off got=%b exp=0", cheat_mode);
        else passed++;
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd7);
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b1) $display("FAIL cheat_restart got=%b exp=1", cheat_mode);
        else passed++;
    endtask

    task automatic test_cheat_abort;
        press_key(4'd1);
        press_key(4'd3);
        keyIsPressed = 1'b1;
        keyCode      = 4'd6;
        frame_after(40);
        total++;
        if (mv !== 5'b00010) $display("FAIL abort_right got=%b exp=%b", mv, 5'b00010);
        else passed++;
        frame_after(40);
        keyIsPressed = 1'b0;
        keyCode      = 4'd0;
        frame_after(40);
        press_key(4'd7);
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b1) $display("FAIL abort_cheat got=%b exp=1", cheat_mode);
        else passed++;
    endtask

    task automatic test_timeout;
        press_key(4'd1);
        press_key(4'd3);
        for (int f = 0; f < 121; f++) frame_after(40);
        press_key(4'd7);
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b1) $display("FAIL timeout_cheat got=%b exp=1", cheat_mode);
        else passed++;
    endtask

    task automatic test_reset_midseq;
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd7);
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cheat_mode !== 1'b0) $display("FAIL midreset_cheat got=%b exp=0", cheat_mode);
        else passed++;
        resetN = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b0) $display("FAIL midreset_idle got=%b exp=0", cheat_mode);
        else passed++;
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd7);
        press_key(4'd9);
        total++;
        if (cheat_mode !== 1'b1) $display("FAIL midreset_recover got=%b exp=1", cheat_mode);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_right_hold;
        test_bounce;
        test_jump;
        test_jump_coincident;
        test_cheat;
        test_cheat_abort;
        test_timeout;
        test_reset_midseq;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
